// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and halt drain.
// Optional write-back bypass into the captured operands: define ID_WB_BYPASS_EN.
module id_ex_hazard_stage #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned CTRL_W       = 12,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned STALL_CNT_W  = 16
) (
  input  logic                   i_clock,
  input  logic                   i_soft_reset,
  input  logic                   i_enable_pipeline,
  input  logic                   i_valid,
  input  logic [REG_ADDR_W-1:0]  i_rs,
  input  logic [REG_ADDR_W-1:0]  i_rt,
  input  logic [REG_ADDR_W-1:0]  i_rd,
  input  logic                   i_uses_rs,
  input  logic                   i_uses_rt,
  input  logic [DATA_W-1:0]      i_data_A,
  input  logic [DATA_W-1:0]      i_data_B,
  input  logic [DATA_W-1:0]      i_imm_ext,
  input  logic [CTRL_W-1:0]      i_ctrl,
  input  logic                   i_mem_read,
  input  logic                   i_reg_write,
  input  logic                   i_halt,
  input  logic [ADDR_W-1:0]      i_pc_next,
  input  logic                   i_wb_write,
  input  logic [REG_ADDR_W-1:0]  i_wb_reg,
  input  logic [DATA_W-1:0]      i_wb_data,
  output logic                   o_stall,
  output logic                   o_valid,
  output logic                   o_mem_read,
  output logic                   o_reg_write,
  output logic                   o_halt_detected,
  output logic [REG_ADDR_W-1:0]  o_rs,
  output logic [REG_ADDR_W-1:0]  o_rt,
  output logic [REG_ADDR_W-1:0]  o_rd,
  output logic [DATA_W-1:0]      o_data_A,
  output logic [DATA_W-1:0]      o_data_B,
  output logic [DATA_W-1:0]      o_imm_ext,
  output logic [CTRL_W-1:0]      o_ctrl,
  output logic [ADDR_W-1:0]      o_pc_next,
  output logic                   o_halted,
  output logic [STALL_CNT_W-1:0] o_stall_count
);

  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic                  mem_read;
    logic                  reg_write;
    logic                  halt_det;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data_a;
    logic [DATA_W-1:0]     data_b;
    logic [DATA_W-1:0]     imm;
    logic [CTRL_W-1:0]     ctrl;
    logic [ADDR_W-1:0]     pc;
  } payload_t;

  state_t                 state_q, state_d;
  logic [DRAIN_W-1:0]     drain_q, drain_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  payload_t               pay_q, pay_d;
  payload_t               capture;
  logic                   hz;

  // A bubble kills every side effect but leaves the datapath fields untouched.
  function automatic payload_t bubble(input payload_t p);
    payload_t b;
    b           = p;
    b.valid     = 1'b0;
    b.mem_read  = 1'b0;
    b.reg_write = 1'b0;
    b.halt_det  = 1'b0;
    b.ctrl      = '0;
    return b;
  endfunction

  assign hz = pay_q.valid && pay_q.mem_read && (pay_q.rt != '0) && i_valid &&
              ((i_uses_rs && (i_rs == pay_q.rt)) || (i_uses_rt && (i_rt == pay_q.rt)));

  always_comb begin
    capture           = '0;
    capture.valid     = i_valid;
    capture.mem_read  = i_mem_read;
    capture.reg_write = i_reg_write;
    capture.halt_det  = i_valid && i_halt;
    capture.rs        = i_rs;
    capture.rt        = i_rt;
    capture.rd        = i_rd;
    capture.imm       = i_imm_ext;
    capture.ctrl      = i_ctrl;
    capture.pc        = i_pc_next;
`ifdef ID_WB_BYPASS_EN
    capture.data_a = (i_wb_write && (i_wb_reg != '0) && (i_wb_reg == i_rs)) ? i_wb_data : i_data_A;
    capture.data_b = (i_wb_write && (i_wb_reg != '0) && (i_wb_reg == i_rt)) ? i_wb_data : i_data_B;
`else
    capture.data_a = i_data_A;
    capture.data_b = i_data_B;
`endif
  end

`ifndef ID_WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{i_wb_write, i_wb_reg, i_wb_data};
`endif

  // Next-state: hazard bubble, capture, or drain toward HALTED.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    stall_cnt_d = stall_cnt_q;
    pay_d       = pay_q;
    if (i_enable_pipeline) begin
      case (state_q)
        ST_RUN: begin
          if (hz) begin
            pay_d = bubble(pay_q);
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
          end else begin
            pay_d = capture;
            if (i_valid && i_halt) begin
              state_d = ST_DRAIN;
              drain_d = DRAIN_W'(DRAIN_CYCLES);
            end
          end
        end
        ST_DRAIN: begin
          pay_d   = bubble(pay_q);
          drain_d = drain_q - DRAIN_W'(1);
          if (drain_q == DRAIN_W'(1)) state_d = ST_HALTED;
        end
        ST_HALTED: pay_d = bubble(pay_q);
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_soft_reset) begin
      state_q     <= ST_RUN;
      drain_q     <= '0;
      stall_cnt_q <= '0;
      pay_q       <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      pay_q       <= pay_d;
    end
  end

  assign o_stall         = hz || (state_q != ST_RUN);
  assign o_valid         = pay_q.valid;
  assign o_mem_read      = pay_q.mem_read;
  assign o_reg_write     = pay_q.reg_write;
  assign o_halt_detected = pay_q.halt_det;
  assign o_rs            = pay_q.rs;
  assign o_rt            = pay_q.rt;
  assign o_rd            = pay_q.rd;
  assign o_data_A        = pay_q.data_a;
  assign o_data_B        = pay_q.data_b;
  assign o_imm_ext       = pay_q.imm;
  assign o_ctrl          = pay_q.ctrl;
  assign o_pc_next       = pay_q.pc;
  assign o_halted        = (state_q == ST_HALTED);
  assign o_stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Scoreboard bench for id_ex_hazard_stage (DRAIN_CYCLES=3, STALL_CNT_W=2).
module tb_id_ex_hazard_stage;

  typedef struct packed {
    logic        valid, mem_read, reg_write, halt_det;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, imm;
    logic [11:0] ctrl;
    logic [10:0] pc;
    logic        halted;
    logic [1:0]  cnt;
  } obs_t;

  typedef struct packed {
    logic        rst, en, valid;
    logic [4:0]  rs, rt, rd;
    logic        uses_rs, uses_rt;
    logic [31:0] a, b, imm;
    logic [11:0] ctrl;
    logic        mem_read, reg_write, halt;
    logic [10:0] pc;
    logic        wb_write;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
  } in_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t  in;
  obs_t m;
  obs_t sb[$];
  int   m_st, m_dc;
  int   total = 0, bad = 0, step = 0;
  logic last_stall;

  logic        o_stall, o_valid, o_mem_read, o_reg_write, o_halt_detected, o_halted;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic [31:0] o_data_A, o_data_B, o_imm_ext;
  logic [11:0] o_ctrl;
  logic [10:0] o_pc_next;
  logic [1:0]  o_stall_count;

  id_ex_hazard_stage #(.DRAIN_CYCLES(3), .STALL_CNT_W(2)) dut (
    .i_clock(clk), .i_soft_reset(in.rst), .i_enable_pipeline(in.en), .i_valid(in.valid),
    .i_rs(in.rs), .i_rt(in.rt), .i_rd(in.rd), .i_uses_rs(in.uses_rs), .i_uses_rt(in.uses_rt),
    .i_data_A(in.a), .i_data_B(in.b), .i_imm_ext(in.imm), .i_ctrl(in.ctrl),
    .i_mem_read(in.mem_read), .i_reg_write(in.reg_write), .i_halt(in.halt), .i_pc_next(in.pc),
    .i_wb_write(in.wb_write), .i_wb_reg(in.wb_reg), .i_wb_data(in.wb_data),
    .o_stall(o_stall), .o_valid(o_valid), .o_mem_read(o_mem_read), .o_reg_write(o_reg_write),
    .o_halt_detected(o_halt_detected), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
    .o_data_A(o_data_A), .o_data_B(o_data_B), .o_imm_ext(o_imm_ext), .o_ctrl(o_ctrl),
    .o_pc_next(o_pc_next), .o_halted(o_halted), .o_stall_count(o_stall_count)
  );

  function automatic logic model_hz();
    return m.valid && m.mem_read && (m.rt != 5'd0) && in.valid &&
           ((in.uses_rs && in.rs == m.rt) || (in.uses_rt && in.rt == m.rt));
  endfunction

  task automatic kill();
    m.valid = 0; m.mem_read = 0; m.reg_write = 0; m.halt_det = 0; m.ctrl = '0;
  endtask

  task automatic model_step();
    logic hz;
    hz = model_hz();
    if (in.rst) begin
      m = '0; m_st = 0; m_dc = 0;
    end else if (in.en) begin
      if (m_st == 0) begin
        if (hz) begin
          kill();
          if (m.cnt != 2'd3) m.cnt = m.cnt + 2'd1;
        end else begin
          m.valid = in.valid; m.mem_read = in.mem_read; m.reg_write = in.reg_write;
          m.halt_det = in.valid & in.halt;
          m.rs = in.rs; m.rt = in.rt; m.rd = in.rd; m.imm = in.imm; m.ctrl = in.ctrl; m.pc = in.pc;
          m.a = in.a; m.b = in.b;
`ifdef ID_WB_BYPASS_EN
          if (in.wb_write && in.wb_reg != 0 && in.wb_reg == in.rs) m.a = in.wb_data;
          if (in.wb_write && in.wb_reg != 0 && in.wb_reg == in.rt) m.b = in.wb_data;
`endif
          if (in.valid && in.halt) begin m_st = 1; m_dc = 3; end
        end
      end else if (m_st == 1) begin
        kill();
        m_dc = m_dc - 1;
        if (m_dc == 0) m_st = 2;
      end else begin
        kill();
      end
    end
    m.halted = (m_st == 2);
  endtask

  // One clock: check the combinational stall, push expectation, compare after the edge.
  task automatic cyc();
    obs_t exp, act;
    @(negedge clk);
    last_stall = o_stall;
    total++;
    if (o_stall !== (model_hz() || m_st != 0)) begin
      bad++;
      $display("FAIL stall step=%0d got=%b want=%b", step, o_stall, (model_hz() || m_st != 0));
    end
    model_step();
    sb.push_back(m);
    @(posedge clk); #1;
    step++;
    exp = sb.pop_front();
    act = '{o_valid, o_mem_read, o_reg_write, o_halt_detected, o_rs, o_rt, o_rd,
            o_data_A, o_data_B, o_imm_ext, o_ctrl, o_pc_next, o_halted, o_stall_count};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL outputs step=%0d got=%h want=%h", step, act, exp);
    end
  endtask

  task automatic instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic mr, input logic hlt);
    in.rst = 0; in.en = 1; in.valid = v; in.rs = rs; in.rt = rt; in.rd = 5'($urandom);
    in.uses_rs = urs; in.uses_rt = urt; in.a = $urandom; in.b = $urandom; in.imm = $urandom;
    in.ctrl = 12'($urandom); in.mem_read = mr; in.reg_write = 1'($urandom); in.halt = hlt;
    in.pc = 11'($urandom); in.wb_write = 0; in.wb_reg = '0; in.wb_data = '0;
  endtask

  task automatic do_reset();
    instr(0, 0, 0, 0, 0, 0, 0);
    in.rst = 1;
    cyc();
    in.rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({o_valid, o_mem_read, o_halted, o_stall_count, o_data_A, o_ctrl} !== '0) begin
      bad++; $display("FAIL reset_zero got=%b want=0", {o_valid, o_mem_read, o_halted, o_stall_count});
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    instr(1, 1, 2, 1, 1, 0, 1); cyc();   // halt captured
    instr(1, 3, 4, 1, 1, 0, 0); cyc();   // drain counter now 2
    in.rst = 1; cyc(); in.rst = 0;
    total++;
    if ({o_valid, o_halt_detected, o_halted, o_rs, o_data_A, o_pc_next, o_stall_count} !== '0) begin
      bad++; $display("FAIL reset_mid_drain got=%h want=0", {o_valid, o_halt_detected, o_halted, o_rs, o_data_A});
    end
    #1;
    total++;
    if (o_stall !== 1'b0) begin bad++; $display("FAIL reset_mid_drain_stall got=%b want=0", o_stall); end
  endtask

  task automatic test_load_use();
    do_reset();
    instr(1, 1, 5, 1, 0, 1, 0); cyc();   // lw $5
    instr(1, 5, 2, 1, 1, 0, 0); cyc();   // uses $5: bubble
    total++;
    if ({last_stall, o_valid, o_stall_count} !== {1'b1, 1'b0, 2'd1}) begin
      bad++; $display("FAIL load_use_bubble got=%b want=101", {last_stall, o_valid, o_stall_count});
    end
    cyc();                               // retried instruction captured
    total++;
    if ({last_stall, o_valid, o_rs, o_stall_count} !== {1'b0, 1'b1, 5'd5, 2'd1}) begin
      bad++; $display("FAIL load_use_retry got=%h want=%h", {last_stall, o_valid, o_rs, o_stall_count}, {1'b0, 1'b1, 5'd5, 2'd1});
    end
  endtask

  task automatic test_no_false_hazard();
    do_reset();
    instr(1, 1, 0, 1, 0, 1, 0); cyc();
    instr(1, 0, 0, 1, 1, 0, 0); cyc();
    total++;
    if (last_stall !== 1'b0) begin bad++; $display("FAIL no_hazard_r0 got=%b want=0", last_stall); end
    instr(1, 2, 5, 1, 0, 1, 0); cyc();
    instr(1, 3, 5, 1, 0, 0, 0); cyc();
    total++;
    if (last_stall !== 1'b0) begin bad++; $display("FAIL no_hazard_unused_rt got=%b want=0", last_stall); end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    do_reset();
    instr(1, 7, 3, 1, 1, 0, 0);
    in.a = 32'h1; in.wb_write = 1; in.wb_reg = 5'd7; in.wb_data = 32'hDEADBEEF;
`ifdef ID_WB_BYPASS_EN
    want = 32'hDEADBEEF;
`else
    want = 32'h1;
`endif
    cyc();
    total++;
    if (o_data_A !== want) begin bad++; $display("FAIL bypass_a got=%h want=%h", o_data_A, want); end
    instr(1, 0, 0, 1, 1, 0, 0);
    in.a = 32'h22; in.wb_write = 1; in.wb_reg = 5'd0; in.wb_data = 32'h12345678;
    cyc();
    total++;
    if (o_data_A !== 32'h22) begin bad++; $display("FAIL bypass_r0 got=%h want=00000022", o_data_A); end
  endtask

  task automatic test_halt_drain();
    logic [4:0] en_pat;
    en_pat = 5'b11001;                   // bit k = enable on clock k after capture
    do_reset();
    instr(1, 1, 2, 1, 1, 0, 1); cyc();
    total++;
    if (o_halt_detected !== 1'b1) begin bad++; $display("FAIL halt_detected got=%b want=1", o_halt_detected); end
    for (int k = 0; k < 5; k++) begin
      instr(1, 5'(k + 3), 5'd4, 1, 1, 0, 0);
      in.en = en_pat[k];
      cyc();
      total++;
      if ({last_stall, o_halt_detected, o_halted} !== {1'b1, 1'b0, (k == 4)}) begin
        bad++; $display("FAIL halt_drain clk=%0d got=%b want=%b", k + 1, {last_stall, o_halt_detected, o_halted}, {1'b1, 1'b0, (k == 4)});
      end
    end
    for (int k = 0; k < 3; k++) begin instr(1, 1, 1, 1, 1, 1, 1); cyc(); end
    total++;
    if ({o_halted, o_valid} !== 2'b10) begin bad++; $display("FAIL halted_hold got=%b want=10", {o_halted, o_valid}); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int p = 0; p < 5; p++) begin
      instr(1, 1, 5, 1, 0, 1, 0); cyc();
      instr(1, 2, 5, 0, 1, 0, 0); cyc(); cyc();
    end
    total++;
    if (o_stall_count !== 2'd3) begin bad++; $display("FAIL stall_saturate got=%0d want=3", o_stall_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      instr(1'($urandom_range(0, 4) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 40) == 0));
      in.en = ($urandom_range(0, 4) != 0);
      in.wb_write = 1'($urandom); in.wb_reg = 5'($urandom_range(0, 3)); in.wb_data = $urandom;
      in.rst = ($urandom_range(0, 30) == 0);
      cyc();
    end
  endtask

  initial begin
    instr(0, 0, 0, 0, 0, 0, 0);
    in.rst = 1;
    m = '0; m_st = 0; m_dc = 0;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_bypass();
    test_halt_drain();
    test_reset_mid_drain();
    test_saturation();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
